// File: rtl/vga_pkg.sv
// Timing constants for the VESA 800x600 @ 60 Hz raster (40 MHz pixel clock)
// and the small types shared by the timing generator and its consumers.
package vga_pkg;

  localparam int HOR_PIXELS      = 800;
  localparam int VER_PIXELS      = 600;

  localparam int HOR_TOTAL_TIME  = 1056;
  localparam int HOR_BLANK_START = HOR_PIXELS;
  localparam int HOR_SYNC_START  = 840;
  localparam int HOR_SYNC_TIME   = 128;

  localparam int VER_TOTAL_TIME  = 628;
  localparam int VER_BLANK_START = VER_PIXELS;
  localparam int VER_SYNC_START  = 601;
  localparam int VER_SYNC_TIME   = 4;

  localparam int CNT_W   = 11;
  localparam int FRAME_W = 16;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [FRAME_W-1:0] frame_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
  } flags_t;

  // Half-open window test [lo, hi), unsigned.
  function automatic logic in_range(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster position and sync/blank bundle produced by the timing generator
// and consumed by the background/draw stages.
interface vga_timing_if;
  import vga_pkg::*;

  cnt_t   hcount;
  cnt_t   vcount;
  logic   hsync;
  logic   vsync;
  logic   hblnk;
  logic   vblnk;
  logic   sof;
  frame_t frame_cnt;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, sof, frame_cnt
  );

  modport slave (
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, sof, frame_cnt
  );

endinterface

// File: rtl/vga_timing.sv
// Free-running raster timing generator. Counters and flags are registered
// together so every output describes the same (hcount, vcount) position.
module vga_timing
  import vga_pkg::*;
#(
  parameter int HOR_TOTAL_TIME  = vga_pkg::HOR_TOTAL_TIME,
  parameter int HOR_BLANK_START = vga_pkg::HOR_BLANK_START,
  parameter int HOR_SYNC_START  = vga_pkg::HOR_SYNC_START,
  parameter int HOR_SYNC_TIME   = vga_pkg::HOR_SYNC_TIME,
  parameter int VER_TOTAL_TIME  = vga_pkg::VER_TOTAL_TIME,
  parameter int VER_BLANK_START = vga_pkg::VER_BLANK_START,
  parameter int VER_SYNC_START  = vga_pkg::VER_SYNC_START,
  parameter int VER_SYNC_TIME   = vga_pkg::VER_SYNC_TIME
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam cnt_t H_LAST    = cnt_t'(HOR_TOTAL_TIME - 1);
  localparam cnt_t V_LAST    = cnt_t'(VER_TOTAL_TIME - 1);
  localparam cnt_t H_BLANK   = cnt_t'(HOR_BLANK_START);
  localparam cnt_t V_BLANK   = cnt_t'(VER_BLANK_START);
  localparam cnt_t H_SYNC_LO = cnt_t'(HOR_SYNC_START);
  localparam cnt_t H_SYNC_HI = cnt_t'(HOR_SYNC_START + HOR_SYNC_TIME);
  localparam cnt_t V_SYNC_LO = cnt_t'(VER_SYNC_START);
  localparam cnt_t V_SYNC_HI = cnt_t'(VER_SYNC_START + VER_SYNC_TIME);

  cnt_t   hcount_q, hcount_d;
  cnt_t   vcount_q, vcount_d;
  logic   h_wrap, f_wrap;
  flags_t flags_q, flags_d;
  logic   sof_q;
  frame_t frame_cnt_q;

  // Flags are derived from the next counter values so that they land in the
  // same register stage as the position they describe.
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    f_wrap   = h_wrap && (vcount_q == V_LAST);
    hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
    end
    flags_d       = '0;
    flags_d.hsync = in_range(hcount_d, H_SYNC_LO, H_SYNC_HI);
    flags_d.vsync = in_range(vcount_d, V_SYNC_LO, V_SYNC_HI);
    flags_d.hblnk = (hcount_d >= H_BLANK);
    flags_d.vblnk = (vcount_d >= V_BLANK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vcount_q <= '0;
    end else begin
      vcount_q <= vcount_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q     <= '0;
      sof_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      flags_q <= flags_d;
      sof_q   <= f_wrap;
      if (f_wrap) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign vga.hcount    = hcount_q;
  assign vga.vcount    = vcount_q;
  assign vga.hsync     = flags_q.hsync;
  assign vga.vsync     = flags_q.vsync;
  assign vga.hblnk     = flags_q.hblnk;
  assign vga.vblnk     = flags_q.vblnk;
  assign vga.sof       = sof_q;
  assign vga.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench: full-size instance for reset/line timing, shrunken
// raster instance for frame-level timing, sof and frame counter wrap.
module tb_vga_timing;
  import vga_pkg::*;

  localparam int S_HT = 20;
  localparam int S_HB = 16;
  localparam int S_HS = 17;
  localparam int S_HW = 2;
  localparam int S_VT = 12;
  localparam int S_VB = 9;
  localparam int S_VS = 10;
  localparam int S_VW = 2;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int S_RUN   = 2 * S_FRAME + 30;

  logic clk     = 1'b0;
  logic rst_big = 1'b1;
  logic rst_sml = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  vga_timing_if big_if ();
  vga_timing_if sml_if ();

  vga_timing dut_big (
    .clk (clk),
    .rst (rst_big),
    .vga (big_if)
  );

  vga_timing #(
    .HOR_TOTAL_TIME  (S_HT),
    .HOR_BLANK_START (S_HB),
    .HOR_SYNC_START  (S_HS),
    .HOR_SYNC_TIME   (S_HW),
    .VER_TOTAL_TIME  (S_VT),
    .VER_BLANK_START (S_VB),
    .VER_SYNC_START  (S_VS),
    .VER_SYNC_TIME   (S_VW)
  ) dut_sml (
    .clk (clk),
    .rst (rst_sml),
    .vga (sml_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int h;
    int v;
    bit hs;
    bit hb;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] pk(input int h, input int v, input logic hs, input logic vs,
                                     input logic hb, input logic vb, input logic sof, input int fc);
    return {21'b0, 11'(h), 11'(v), hs, vs, hb, vb, sof, 16'(fc)};
  endfunction

  function automatic logic [63:0] pk_big();
    return {21'b0, big_if.hcount, big_if.vcount, big_if.hsync, big_if.vsync,
            big_if.hblnk, big_if.vblnk, big_if.sof, big_if.frame_cnt};
  endfunction

  function automatic logic [63:0] pk_sml();
    return {21'b0, sml_if.hcount, sml_if.vcount, sml_if.hsync, sml_if.vsync,
            sml_if.hblnk, sml_if.vblnk, sml_if.sof, sml_if.frame_cnt};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int t, eh, ev;
    logic ehs, evs, ehb, evb, esof;
    int vs_hi, vb_hi, sof_seen, fall0, fall1;
    logic prev_vs;
    logic [15:0] prev_fc;
    bit found;

    // Line-timing vectors: n = rising edges since reset release.
    vecs.push_back('{0,    0,    0, 0, 0});
    vecs.push_back('{1,    1,    0, 0, 0});
    vecs.push_back('{2,    2,    0, 0, 0});
    vecs.push_back('{3,    3,    0, 0, 0});
    vecs.push_back('{799,  799,  0, 0, 0});
    vecs.push_back('{800,  800,  0, 0, 1});
    vecs.push_back('{839,  839,  0, 0, 1});
    vecs.push_back('{840,  840,  0, 1, 1});
    vecs.push_back('{967,  967,  0, 1, 1});
    vecs.push_back('{968,  968,  0, 0, 1});
    vecs.push_back('{1055, 1055, 0, 0, 1});
    vecs.push_back('{1056, 0,    1, 0, 0});
    vecs.push_back('{1057, 1,    1, 0, 0});

    repeat (20) @(negedge clk);
    check("reset_hold_big", pk_big(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    check("reset_hold_sml", pk_sml(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_big = 1'b0;

    repeat (500) @(negedge clk);
    check("pre_midline_reset", pk_big(), pk(500, 0, 0, 0, 0, 0, 0, 0));
    #2 rst_big = 1'b1;
    #1 check("async_midline_reset", pk_big(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    rst_big = 1'b0;

    edges = 0;
    foreach (vecs[i]) begin
      while (edges < vecs[i].n) begin
        @(negedge clk);
        edges++;
      end
      #1;
      check($sformatf("line_vec n=%0d", vecs[i].n), pk_big(),
            pk(vecs[i].h, vecs[i].v, vecs[i].hs, 1'b0, vecs[i].hb, 1'b0, 1'b0, 0));
    end

    // Shrunken raster: per-cycle positional model across two frames.
    @(negedge clk);
    rst_sml = 1'b0;
    vs_hi = 0; vb_hi = 0; sof_seen = 0; fall0 = -1; fall1 = -1;
    prev_vs = 1'b0;
    for (int k = 1; k <= S_RUN; k++) begin
      @(negedge clk);
      t    = k % S_FRAME;
      eh   = t % S_HT;
      ev   = t / S_HT;
      ehs  = (eh >= S_HS) && (eh < S_HS + S_HW);
      evs  = (ev >= S_VS) && (ev < S_VS + S_VW);
      ehb  = (eh >= S_HB);
      evb  = (ev >= S_VB);
      esof = (t == 0);
      check($sformatf("frame_model k=%0d", k), pk_sml(),
            pk(eh, ev, ehs, evs, ehb, evb, esof, k / S_FRAME));
      if (k < S_FRAME && sml_if.vsync) vs_hi++;
      if (k < S_FRAME && sml_if.vblnk) vb_hi++;
      if (sml_if.sof) sof_seen++;
      if (prev_vs && !sml_if.vsync) begin
        if (fall0 < 0) fall0 = k;
        else if (fall1 < 0) fall1 = k;
      end
      prev_vs = sml_if.vsync;
    end
    check("vsync_width", 64'(vs_hi), 64'(S_VW * S_HT));
    check("vblnk_width", 64'(vb_hi), 64'((S_VT - S_VB) * S_HT));
    check("sof_count", 64'(sof_seen), 64'd2);
    check("vsync_first_fall", 64'(fall0), 64'(S_FRAME));
    check("vsync_period", 64'(fall1 - fall0), 64'(S_FRAME));

    // Frame counter wrap: preload 0xFFFF mid-frame, expect 0 on next sof.
    force dut_sml.frame_cnt_q = 16'hFFFF;
    #1 release dut_sml.frame_cnt_q;
    #1 check("preload_fc", 64'(sml_if.frame_cnt), 64'h FFFF);
    found = 1'b0;
    prev_fc = sml_if.frame_cnt;
    for (int k = 0; k < S_FRAME + 5; k++) begin
      @(negedge clk);
      if (sml_if.sof) begin
        found = 1'b1;
        break;
      end
      prev_fc = sml_if.frame_cnt;
    end
    check("wrap_sof_found", 64'(found), 64'd1);
    check("wrap_fc_before", 64'(prev_fc), 64'h FFFF);
    check("wrap_fc_at_sof", pk_sml(), pk(0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    check("wrap_after_sof", pk_sml(), pk(1, 0, 0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
